lcd_stream_to_bus_writer: RTL and testbench

//  Avalon-ST sink that drains the 8-bit LCD byte stream (SOP/EOP framed) and drives
//  the parallel LCD write bus with programmable setup/strobe/hold timing.

---
 rtl/lcd_stream_to_bus_writer_if.sv | 19 +
 rtl/lcd_stream_to_bus_writer.sv | 132 +++++++++++++
 tb/tb_lcd_stream_to_bus_writer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_stream_to_bus_writer_if.sv
// Avalon-ST byte stream carrying SOP/EOP-framed LCD command/data packets.
// The source drives master, the LCD bus writer consumes through slave.
interface lcd_stream_to_bus_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_startofpacket;
  logic       in_endofpacket;

  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket,
    output in_ready
  );
endinterface

// File: rtl/lcd_stream_to_bus_writer.sv
// Drains the framed LCD byte stream onto a parallel write bus with programmable
// setup/strobe/hold timing; the SOP byte is a command (rs=0), later bytes are data.
module lcd_stream_to_bus_writer #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  lcd_stream_to_bus_writer_if.slave   st,
  output logic                        lcd_cs_n,
  output logic                        lcd_rs,
  output logic                        lcd_wr_n,
  output logic [7:0]                  lcd_data,
  output logic                        busy,
  output logic                        protocol_error
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_n_q, cs_n_d;
  logic             rs_q, rs_d;
  logic             wr_n_q, wr_n_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic             in_packet_q, in_packet_d;
  logic             perr_q, perr_d;
  logic             accept;

  assign st.in_ready = (state_q == IDLE) && !reset;
  assign accept      = st.in_valid && st.in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    rs_d        = rs_q;
    wr_n_d      = wr_n_q;
    data_d      = data_q;
    last_d      = last_q;
    in_packet_d = in_packet_q;
    perr_d      = perr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // A data byte with no open packet is swallowed without touching the bus.
          if (!st.in_startofpacket && !in_packet_q) begin
            perr_d = 1'b1;
          end else begin
            if (st.in_startofpacket && in_packet_q) perr_d = 1'b1;
            if (st.in_startofpacket) in_packet_d = 1'b1;
            data_d  = st.in_data;
            rs_d    = !st.in_startofpacket;
            cs_n_d  = 1'b0;
            last_d  = st.in_endofpacket;
            state_d = SETUP;
            cnt_d   = SETUP_LOAD;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
          wr_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (last_q) begin
            cs_n_d      = 1'b1;
            in_packet_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      rs_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      in_packet_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      rs_q        <= rs_d;
      wr_n_q      <= wr_n_d;
      data_q      <= data_d;
      last_q      <= last_d;
      in_packet_q <= in_packet_d;
      perr_q      <= perr_d;
    end
  end

  assign lcd_cs_n       = cs_n_q;
  assign lcd_rs         = rs_q;
  assign lcd_wr_n       = wr_n_q;
  assign lcd_data       = data_q;
  assign busy           = (state_q != IDLE) || in_packet_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_lcd_stream_to_bus_writer.sv
// Bench for lcd_stream_to_bus_writer: default-timing and 1/1/1-timing instances
// checked every cycle against a byte-timeline model plus literal expectations.
module tb_lcd_stream_to_bus_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_stream_to_bus_writer_if s0();
  lcd_stream_to_bus_writer_if s1();

  logic cs_n0, rs0, wr_n0, busy0, perr0;
  logic cs_n1, rs1, wr_n1, busy1, perr1;
  logic [7:0] data0, data1;

  lcd_stream_to_bus_writer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .st(s0),
    .lcd_cs_n(cs_n0), .lcd_rs(rs0), .lcd_wr_n(wr_n0), .lcd_data(data0),
    .busy(busy0), .protocol_error(perr0)
  );

  lcd_stream_to_bus_writer #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .st(s1),
    .lcd_cs_n(cs_n1), .lcd_rs(rs1), .lcd_wr_n(wr_n1), .lcd_data(data1),
    .busy(busy1), .protocol_error(perr1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Behavioural model: each accepted byte occupies edges start..start+S+W+H,
  // with wr_n low for offsets [S, S+W).
  int         Sp[2] = '{2, 1};
  int         Wp[2] = '{3, 1};
  int         Hp[2] = '{2, 1};
  int         m_start[2];
  bit         m_active[2];
  bit         m_last[2];
  bit         m_pkt[2];
  bit         m_perr[2];
  bit         m_cs_n[2];
  bit         m_rs[2];
  logic [7:0] m_data[2];

  int         acc_log[2][$];
  int         low_log[2][$];
  int         csr_log[2][$];
  logic [8:0] strobe_log[2][$];
  bit         prev_wr[2] = '{1'b1, 1'b1};
  bit         prev_cs[2] = '{1'b1, 1'b1};
  int         run[2] = '{0, 0};

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp_v);
  endtask

  task automatic chkb(input string nm, input int d, input logic act, input logic exp_v);
    chk(nm, d, {31'd0, act}, {31'd0, exp_v});
  endtask

  task automatic model_step(input int d, input logic v, input logic sop, input logic eop,
                            input logic [7:0] dat);
    if (reset) begin
      m_active[d] = 1'b0; m_pkt[d] = 1'b0; m_perr[d] = 1'b0; m_last[d] = 1'b0;
      m_cs_n[d] = 1'b1; m_rs[d] = 1'b0; m_data[d] = 8'h00;
    end else if (m_active[d]) begin
      if (cyc - m_start[d] == Sp[d] + Wp[d] + Hp[d]) begin
        m_active[d] = 1'b0;
        if (m_last[d]) begin
          m_cs_n[d] = 1'b1;
          m_pkt[d]  = 1'b0;
        end
      end
    end else if (v) begin
      if (!sop && !m_pkt[d]) begin
        m_perr[d] = 1'b1;
      end else begin
        if (sop && m_pkt[d]) m_perr[d] = 1'b1;
        if (sop) m_pkt[d] = 1'b1;
        m_active[d] = 1'b1;
        m_start[d]  = cyc;
        m_data[d]   = dat;
        m_rs[d]     = !sop;
        m_cs_n[d]   = 1'b0;
        m_last[d]   = eop;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step(0, s0.in_valid, s0.in_startofpacket, s0.in_endofpacket, s0.in_data);
    model_step(1, s1.in_valid, s1.in_startofpacket, s1.in_endofpacket, s1.in_data);
  end

  task automatic cycle_check(input int d, input logic rdy, input logic cs, input logic rs_,
                             input logic wr, input logic bz, input logic pe, input logic [7:0] dt);
    int off;
    logic ewr;
    off = cyc - m_start[d];
    ewr = !(m_active[d] && off >= Sp[d] && off < Sp[d] + Wp[d]);
    chkb("in_ready", d, rdy, !m_active[d] && !reset);
    chkb("lcd_cs_n", d, cs, m_cs_n[d]);
    chkb("lcd_rs", d, rs_, m_rs[d]);
    chkb("lcd_wr_n", d, wr, ewr);
    chk("lcd_data", d, 32'(dt), 32'(m_data[d]));
    chkb("busy", d, bz, m_active[d] || m_pkt[d]);
    chkb("protocol_error", d, pe, m_perr[d]);
  endtask

  task automatic monitor(input int d, input logic v, input logic rdy, input logic cs,
                         input logic rs_, input logic wr, input logic [7:0] dt);
    if (v && rdy) acc_log[d].push_back(cyc);
    if (!wr) begin
      if (prev_wr[d]) strobe_log[d].push_back({rs_, dt});
      run[d]++;
    end else if (!prev_wr[d]) begin
      low_log[d].push_back(run[d]);
      run[d] = 0;
    end
    if (cs && !prev_cs[d]) csr_log[d].push_back(cyc);
    prev_wr[d] = wr;
    prev_cs[d] = cs;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      cycle_check(0, s0.in_ready, cs_n0, rs0, wr_n0, busy0, perr0, data0);
      cycle_check(1, s1.in_ready, cs_n1, rs1, wr_n1, busy1, perr1, data1);
      monitor(0, s0.in_valid, s0.in_ready, cs_n0, rs0, wr_n0, data0);
      monitor(1, s1.in_valid, s1.in_ready, cs_n1, rs1, wr_n1, data1);
    end
  end

  task automatic drive(input int d, input logic v, input logic [7:0] dt, input logic sop, input logic eop);
    if (d == 0) begin
      s0.in_valid = v; s0.in_data = dt; s0.in_startofpacket = sop; s0.in_endofpacket = eop;
    end else begin
      s1.in_valid = v; s1.in_data = dt; s1.in_startofpacket = sop; s1.in_endofpacket = eop;
    end
  endtask

  task automatic send(input int d, input logic [7:0] dt, input logic sop, input logic eop);
    logic r;
    bit done;
    done = 1'b0;
    drive(d, 1'b1, dt, sop, eop);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = (d == 0) ? s0.in_ready : s1.in_ready;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    if (!done) chk("send_timeout", d, 0, 1);
    drive(d, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      acc_log[d].delete(); low_log[d].delete(); csr_log[d].delete(); strobe_log[d].delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [8:0] exp2[3];
    logic [8:0] exp6[4];
    exp2 = '{9'h02C, 9'h111, 9'h122};
    exp6 = '{9'h0A0, 9'h1A1, 9'h1A2, 9'h1A3};
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset held three clocks with a valid byte pending
    reset = 1'b1;
    drive(0, 1'b1, 8'hAA, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_in_ready", 0, s0.in_ready, 1'b0);
    chkb("rst_cs_n", 0, cs_n0, 1'b1);
    chkb("rst_wr_n", 0, wr_n0, 1'b1);
    chkb("rst_perr", 0, perr0, 1'b0);
    chk("rst_no_accept", 0, acc_log[0].size(), 0);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    idle(2);
    chkb("rst_busy", 0, busy0, 1'b0);

    // Three-byte packet back to back
    clear_logs();
    send(0, 8'h2C, 1'b1, 1'b0);
    send(0, 8'h11, 1'b0, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1);
    idle(10);
    chk("t2_nstrobe", 0, strobe_log[0].size(), 3);
    if (strobe_log[0].size() == 3)
      for (int i = 0; i < 3; i++) chk("t2_strobe_rs_data", 0, 32'(strobe_log[0][i]), 32'(exp2[i]));
    chk("t2_nlow", 0, low_log[0].size(), 3);
    if (low_log[0].size() == 3)
      for (int i = 0; i < 3; i++) chk("t2_low_len", 0, low_log[0][i], 3);
    chk("t2_naccept", 0, acc_log[0].size(), 3);
    if (acc_log[0].size() == 3) begin
      chk("t2_accept_gap1", 0, acc_log[0][1] - acc_log[0][0], 8);
      chk("t2_accept_gap2", 0, acc_log[0][2] - acc_log[0][1], 8);
      chk("t2_ncs_rise", 0, csr_log[0].size(), 1);
      if (csr_log[0].size() == 1)
        chk("t2_cs_release", 0, csr_log[0][0] - (acc_log[0][2] + 1), 7);
    end

    // Single-byte command packet
    clear_logs();
    send(0, 8'h01, 1'b1, 1'b1);
    idle(10);
    chk("t3_nstrobe", 0, strobe_log[0].size(), 1);
    if (strobe_log[0].size() == 1) chk("t3_strobe_rs_data", 0, 32'(strobe_log[0][0]), 32'h001);
    chk("t3_ncs_rise", 0, csr_log[0].size(), 1);
    if (csr_log[0].size() == 1 && acc_log[0].size() == 1)
      chk("t3_cs_release", 0, csr_log[0][0] - (acc_log[0][0] + 1), 7);

    // Orphan data byte outside a packet
    clear_logs();
    send(0, 8'h55, 1'b0, 1'b0);
    chkb("t4_ready_next", 0, s0.in_ready, 1'b1);
    chkb("t4_perr", 0, perr0, 1'b1);
    idle(8);
    chk("t4_no_strobe", 0, strobe_log[0].size(), 0);
    chkb("t4_cs_n_high", 0, cs_n0, 1'b1);
    send(0, 8'h2A, 1'b1, 1'b1);
    idle(10);
    chk("t4_good_nstrobe", 0, strobe_log[0].size(), 1);
    if (strobe_log[0].size() == 1) chk("t4_good_strobe", 0, 32'(strobe_log[0][0]), 32'h02A);
    chkb("t4_perr_sticky", 0, perr0, 1'b1);

    // Reset during the strobe of a data byte
    send(0, 8'h2C, 1'b1, 1'b0);
    send(0, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 20 && wr_n0 !== 1'b0; i++) @(negedge clk);
    chkb("t5_reach_strobe", 0, wr_n0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chkb("t5_wr_n", 0, wr_n0, 1'b1);
    chkb("t5_cs_n", 0, cs_n0, 1'b1);
    chkb("t5_busy", 0, busy0, 1'b0);
    chkb("t5_perr_cleared", 0, perr0, 1'b0);
    reset = 1'b0;
    idle(1);
    clear_logs();
    send(0, 8'h2B, 1'b1, 1'b0);
    send(0, 8'h44, 1'b0, 1'b1);
    idle(10);
    chk("t5_nstrobe", 0, strobe_log[0].size(), 2);
    if (strobe_log[0].size() == 2) begin
      chk("t5_strobe0", 0, 32'(strobe_log[0][0]), 32'h02B);
      chk("t5_strobe1", 0, 32'(strobe_log[0][1]), 32'h144);
    end
    chk("t5_ncs_rise", 0, csr_log[0].size(), 1);

    // Minimum timing, four-byte packet with a throttled gap
    clear_logs();
    send(1, 8'hA0, 1'b1, 1'b0);
    send(1, 8'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chkb("t6_gap_cs_n", 1, cs_n1, 1'b0);
      chkb("t6_gap_busy", 1, busy1, 1'b1);
      @(posedge clk);
      #1;
    end
    send(1, 8'hA2, 1'b0, 1'b0);
    send(1, 8'hA3, 1'b0, 1'b1);
    idle(6);
    chk("t6_nstrobe", 1, strobe_log[1].size(), 4);
    if (strobe_log[1].size() == 4)
      for (int i = 0; i < 4; i++) chk("t6_strobe_rs_data", 1, 32'(strobe_log[1][i]), 32'(exp6[i]));
    chk("t6_nlow", 1, low_log[1].size(), 4);
    if (low_log[1].size() == 4)
      for (int i = 0; i < 4; i++) chk("t6_low_len", 1, low_log[1][i], 1);
    chk("t6_naccept", 1, acc_log[1].size(), 4);
    if (acc_log[1].size() == 4) begin
      chk("t6_accept_gap01", 1, acc_log[1][1] - acc_log[1][0], 4);
      chk("t6_accept_gap23", 1, acc_log[1][3] - acc_log[1][2], 4);
      chk("t6_ncs_rise", 1, csr_log[1].size(), 1);
      if (csr_log[1].size() == 1)
        chk("t6_cs_release", 1, csr_log[1][0] - (acc_log[1][3] + 1), 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
